// File: rtl/rv_dbgbr_pkg.sv
// ---------------------------------------------------------------------------
// rv_types -- shared definitions for the rv_dbgbr debug bridge.
//   Command bytes received on the byte link, reply bytes sent back, and the
//   bridge FSM state encoding.
//   Optional macro RV_DBGBR_READ_EN: adds the bus-read states to the enum.
// ---------------------------------------------------------------------------
package rv_types;

  // Command bytes (ASCII).
  localparam logic [7:0] CMD_W = 8'h57;  // 'W' write: addr4 + data4
  localparam logic [7:0] CMD_R = 8'h52;  // 'R' read : addr4
  localparam logic [7:0] CMD_H = 8'h48;  // 'H' hold CPU, take the bus
  localparam logic [7:0] CMD_G = 8'h47;  // 'G' release CPU

  // Reply bytes.
  localparam logic [7:0] RSP_K   = 8'h4B;  // 'K' command done
  localparam logic [7:0] RSP_UNK = 8'h3F;  // '?' unknown command

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_WR,
`ifdef RV_DBGBR_READ_EN
    BUS_RD,
    RD_WAIT,
`endif
    REPLY
  } state_t;

endpackage

// File: rtl/rv_dbgbr_if.sv
// ---------------------------------------------------------------------------
// rv_dbgbr_if -- byte link and bus initiator signals of the debug bridge.
//   rx_data/rx_valid : received command byte, single-cycle strobe
//   tx_data/tx_valid/tx_ready : reply byte stream (valid held until ready)
//   m_adr/m_we/m_dw/m_re : bus request issued by the bridge
//   m_dr/m_rdy : read data (one cycle after the accepted read) and ready
//   modport master : the bridge side; modport slave : link/bus side.
// ---------------------------------------------------------------------------
interface rv_dbgbr_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] m_adr;
  logic [3:0]  m_we;
  logic [31:0] m_dw;
  logic        m_re;
  logic [31:0] m_dr;
  logic        m_rdy;

  modport master (
    input  rx_data, rx_valid, tx_ready, m_dr, m_rdy,
    output tx_data, tx_valid, m_adr, m_we, m_dw, m_re
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, m_dr, m_rdy,
    input  tx_data, tx_valid, m_adr, m_we, m_dw, m_re
  );
endinterface

// File: rtl/rv_dbgbr.sv
// ---------------------------------------------------------------------------
// rv_dbgbr -- byte-stream debug bridge (cclk domain, single clock).
//   Parses little-endian commands from a byte link and turns them into word
//   bus accesses; also holds the CPU in reset on request.
//     'W' a0 a1 a2 a3 d0 d1 d2 d3 -> word write, reply 'K'
//     'R' a0 a1 a2 a3             -> word read, reply 4 data bytes LSB first
//     'H' / 'G'                   -> set / clear hold, reply 'K'
//     anything else in IDLE       -> reply '?'
//   Ports: clk, xreset (async, active low), bus (rv_dbgbr_if.master),
//          hold (CPU held in reset, bus owned by bridge), busy (not IDLE).
//   Parameter TMO_CYCLES: inter-byte timeout inside a command, in clk cycles.
//   Optional macro RV_DBGBR_READ_EN: enables the 'R' command; without it
//   'R' is answered with '?' and m_re is tied low.
// ---------------------------------------------------------------------------
module rv_dbgbr
  import rv_types::*;
#(
  parameter int unsigned TMO_CYCLES = 480000
) (
  input  logic         clk,
  input  logic         xreset,
  rv_dbgbr_if.master   bus,
  output logic         hold,
  output logic         busy
);

  localparam int unsigned TMO_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  state_t            state, state_nxt;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [1:0]        byte_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [23:0]       rep_buf;   // reply bytes still to be presented
  logic [1:0]        rep_left;  // bytes after the one on tx_data
`ifdef RV_DBGBR_READ_EN
  logic              is_rd;
  logic              cmd_rd;
`endif

  // Decode strobes from the next-state logic into the datapath.
  logic              cmd_start;
  logic              byte_acc;
  logic              hold_set;
  logic              hold_clr;
  logic              rep_start;
  logic [31:0]       rep_word;
  logic [1:0]        rep_last;
  logic              tmo_hit;

  // NOTE: the async reset is in the sensitivity list; state changes use <=
  // so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_start = 1'b0;
    byte_acc  = 1'b0;
    hold_set  = 1'b0;
    hold_clr  = 1'b0;
    rep_start = 1'b0;
    rep_word  = 32'h0;
    rep_last  = 2'd0;
`ifdef RV_DBGBR_READ_EN
    cmd_rd    = 1'b0;
`endif
    tmo_hit   = (tmo_cnt == TMO_LAST);

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_W: begin
              cmd_start = 1'b1;
              state_nxt = ADDR;
            end
`ifdef RV_DBGBR_READ_EN
            CMD_R: begin
              cmd_start = 1'b1;
              cmd_rd    = 1'b1;
              state_nxt = ADDR;
            end
`endif
            CMD_H: begin
              hold_set  = 1'b1;
              rep_start = 1'b1;
              rep_word  = {24'h0, RSP_K};
              state_nxt = REPLY;
            end
            CMD_G: begin
              hold_clr  = 1'b1;
              rep_start = 1'b1;
              rep_word  = {24'h0, RSP_K};
              state_nxt = REPLY;
            end
            default: begin
              rep_start = 1'b1;
              rep_word  = {24'h0, RSP_UNK};
              state_nxt = REPLY;
            end
          endcase
        end
      end

      // A byte arriving on the expiry cycle wins over the timeout.
      ADDR: begin
        if (bus.rx_valid) begin
          byte_acc = 1'b1;
          if (byte_cnt == 2'd3) begin
`ifdef RV_DBGBR_READ_EN
            state_nxt = is_rd ? BUS_RD : DATA;
`else
            state_nxt = DATA;
`endif
          end
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end

      DATA: begin
        if (bus.rx_valid) begin
          byte_acc = 1'b1;
          if (byte_cnt == 2'd3) state_nxt = BUS_WR;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end

      BUS_WR: begin
        if (bus.m_rdy) begin
          rep_start = 1'b1;
          rep_word  = {24'h0, RSP_K};
          state_nxt = REPLY;
        end
      end

`ifdef RV_DBGBR_READ_EN
      BUS_RD: begin
        if (bus.m_rdy) state_nxt = RD_WAIT;
      end

      // Read data is valid exactly one cycle after the accepted request.
      RD_WAIT: begin
        rep_start = 1'b1;
        rep_word  = bus.m_dr;
        rep_last  = 2'd3;
        state_nxt = REPLY;
      end
`endif

      REPLY: begin
        if (bus.tx_valid && bus.tx_ready && rep_left == 2'd0) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Bus request is a pure function of state; m_adr/m_dw read zero when idle.
  always_comb begin
    bus.m_we  = 4'h0;
    bus.m_re  = 1'b0;
    bus.m_adr = 32'h0;
    bus.m_dw  = 32'h0;
    if (state == BUS_WR) begin
      bus.m_we  = 4'hF;
      bus.m_adr = {addr_q[31:2], 2'b00};
      bus.m_dw  = data_q;
    end
`ifdef RV_DBGBR_READ_EN
    if (state == BUS_RD) begin
      bus.m_re  = 1'b1;
      bus.m_adr = {addr_q[31:2], 2'b00};
    end
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      hold         <= 1'b1;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      byte_cnt     <= 2'd0;
      tmo_cnt      <= '0;
      rep_buf      <= 24'h0;
      rep_left     <= 2'd0;
      bus.tx_data  <= 8'h0;
      bus.tx_valid <= 1'b0;
`ifdef RV_DBGBR_READ_EN
      is_rd        <= 1'b0;
`endif
    end else begin
      if (hold_set)      hold <= 1'b1;
      else if (hold_clr) hold <= 1'b0;

      if (cmd_start) begin
        byte_cnt <= 2'd0;
`ifdef RV_DBGBR_READ_EN
        is_rd    <= cmd_rd;
`endif
      end

      // Bytes enter at the top so the first (least significant) byte ends
      // up in bits [7:0] after four shifts; byte_cnt wraps 3 -> 0.
      if (byte_acc) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == ADDR) addr_q <= {bus.rx_data, addr_q[31:8]};
        else               data_q <= {bus.rx_data, data_q[31:8]};
      end

      // Runs only while waiting for command bytes; bus waits are unbounded.
      if (byte_acc || !(state == ADDR || state == DATA)) tmo_cnt <= '0;
      else                                                tmo_cnt <= tmo_cnt + 1'b1;

      if (rep_start) begin
        bus.tx_valid <= 1'b1;
        bus.tx_data  <= rep_word[7:0];
        rep_buf      <= rep_word[31:8];
        rep_left     <= rep_last;
      end else if (state == REPLY && bus.tx_valid && bus.tx_ready) begin
        if (rep_left == 2'd0) begin
          bus.tx_valid <= 1'b0;
        end else begin
          bus.tx_data <= rep_buf[7:0];
          rep_buf     <= {8'h0, rep_buf[23:8]};
          rep_left    <= rep_left - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_dbgbr.sv
// ---------------------------------------------------------------------------
// tb_rv_dbgbr -- directed self-checking bench for rv_dbgbr.
//   Drives command bytes, models a word bus with one-cycle read latency,
//   and records reply bytes and bus cycles seen at the active clock edge.
//   Read-specific vectors follow RV_DBGBR_READ_EN.
// ---------------------------------------------------------------------------
module tb_rv_dbgbr;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic xreset;
  logic hold;
  logic busy;

  rv_dbgbr_if bus ();

  rv_dbgbr #(.TMO_CYCLES(TMO)) dut (
    .clk    (clk),
    .xreset (xreset),
    .bus    (bus),
    .hold   (hold),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Observers: reply bytes and bus activity at each active edge.
  logic [7:0]  tx_q[$];
  int          we_cyc   = 0;
  int          re_cyc   = 0;
  int          both_cyc = 0;
  int          wr_cnt   = 0;
  logic [31:0] last_adr = 32'h0;
  logic [31:0] last_dw  = 32'h0;
  logic [3:0]  last_we  = 4'h0;

  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    if (bus.m_we != 4'h0) we_cyc <= we_cyc + 1;
    if (bus.m_re) re_cyc <= re_cyc + 1;
    if (bus.m_re && bus.m_we != 4'h0) both_cyc <= both_cyc + 1;
    if (bus.m_we != 4'h0 && bus.m_rdy) begin
      wr_cnt   <= wr_cnt + 1;
      last_adr <= bus.m_adr;
      last_dw  <= bus.m_dw;
      last_we  <= bus.m_we;
    end
    // Memory model: 0x100 holds 0xDEADBEEF; data only valid for one cycle.
    if (bus.m_re && bus.m_rdy)
      bus.m_dr <= (bus.m_adr == 32'h100) ? 32'hDEADBEEF : 32'h0BAD0BAD;
    else
      bus.m_dr <= 32'hA5A5A5A5;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] txb(input int idx);
    if (idx < tx_q.size()) return tx_q[idx];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_tx(input int base, input int n);
    for (int i = 0; i < 300 && tx_q.size() < base + n; i++) @(negedge clk);
    if (tx_q.size() < base + n) check("tx_wait", tx_q.size() - base, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, w0, we0, re0, bad;

    xreset       = 1'b0;
    bus.rx_data  = 8'h0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    bus.m_rdy    = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_hold",     hold,         1'b1);
    check("rst_busy",     busy,         1'b0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data",  bus.tx_data,  8'h00);
    check("rst_m_we",     bus.m_we,     4'h0);
    check("rst_m_re",     bus.m_re,     1'b0);
    check("rst_m_adr",    bus.m_adr,    32'h0);
    check("rst_m_dw",     bus.m_dw,     32'h0);
    xreset = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xDEADBEEF to 0x100, bus ready immediately.
    base = tx_q.size(); w0 = wr_cnt; we0 = we_cyc;
    send_byte(8'h57); send_word(32'h00000100); send_word(32'hDEADBEEF);
    wait_tx(base, 1);
    check("wr_tx",        txb(base),     8'h4B);
    check("wr_count",     wr_cnt - w0,   1);
    check("wr_we_cycles", we_cyc - we0,  1);
    check("wr_we",        last_we,       4'hF);
    check("wr_adr",       last_adr,      32'h100);
    check("wr_dw",        last_dw,       32'hDEADBEEF);
    check("wr_busy_done", busy,          1'b0);

    // Stalled write to unaligned 0x207; a 'G' arriving mid-stall is dropped.
    bus.m_rdy = 1'b0;
    base = tx_q.size(); w0 = wr_cnt; we0 = we_cyc; bad = 0;
    send_byte(8'h57); send_word(32'h00000207); send_word(32'h11223344);
    for (int i = 0; i < 20; i++) begin
      if (bus.m_we !== 4'hF || bus.m_adr !== 32'h204 ||
          bus.m_dw !== 32'h11223344 || bus.tx_valid !== 1'b0) bad++;
      bus.rx_valid = (i == 5);
      bus.rx_data  = 8'h47;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    bus.m_rdy = 1'b1;
    wait_tx(base, 1);
    repeat (4) @(negedge clk);
    check("stall_stable",    bad,           0);
    check("stall_we_cycles", we_cyc - we0,  21);
    check("stall_wr_count",  wr_cnt - w0,   1);
    check("stall_adr",       last_adr,      32'h204);
    check("stall_dw",        last_dw,       32'h11223344);
    check("stall_tx",        txb(base),     8'h4B);
    check("stall_tx_count",  tx_q.size() - base, 1);
    check("stall_hold_kept", hold,          1'b1);

    // H then G.
    base = tx_q.size();
    send_byte(8'h48); wait_tx(base, 1);
    check("h_tx",   txb(base), 8'h4B);
    check("h_hold", hold,      1'b1);
    send_byte(8'h47); wait_tx(base, 2);
    check("g_tx",   txb(base + 1), 8'h4B);
    check("g_hold", hold,          1'b0);

    // Unknown byte.
    base = tx_q.size();
    send_byte(8'h5A); wait_tx(base, 1);
    check("unk_tx", txb(base), 8'h3F);

`ifdef RV_DBGBR_READ_EN
    // Read 0x100 -> EF BE AD DE.
    base = tx_q.size(); re0 = re_cyc; we0 = we_cyc;
    send_byte(8'h52); send_word(32'h00000100);
    wait_tx(base, 4);
    check("rd_b0",        txb(base),     8'hEF);
    check("rd_b1",        txb(base + 1), 8'hBE);
    check("rd_b2",        txb(base + 2), 8'hAD);
    check("rd_b3",        txb(base + 3), 8'hDE);
    check("rd_re_cycles", re_cyc - re0,  1);
    check("rd_no_write",  we_cyc - we0,  0);
`else
    // Without read support 'R' is an unknown command.
    base = tx_q.size();
    send_byte(8'h52); wait_tx(base, 1);
    check("r_unk_tx",  txb(base), 8'h3F);
    check("r_no_read", re_cyc,    0);
`endif

    // Partial command then silence longer than the timeout.
    base = tx_q.size(); w0 = wr_cnt; we0 = we_cyc;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01);
    repeat (TMO + 3) @(negedge clk);
    check("tmo_idle",  busy,               1'b0);
    check("tmo_no_tx", tx_q.size() - base, 0);
    check("tmo_no_we", we_cyc - we0,       0);
    send_byte(8'h48); wait_tx(base, 1);
    check("tmo_next_h", txb(base), 8'h4B);

    // Byte arriving on the expiry cycle is accepted.
    base = tx_q.size(); w0 = wr_cnt;
    send_byte(8'h57);
    repeat (TMO - 1) @(negedge clk);
    send_word(32'h00000300); send_word(32'h12345678);
    wait_tx(base, 1);
    check("edge_tx",    txb(base),   8'h4B);
    check("edge_count", wr_cnt - w0, 1);
    check("edge_adr",   last_adr,    32'h300);
    check("edge_dw",    last_dw,     32'h12345678);

    // Drop hold so the reset below must restore it.
    base = tx_q.size();
    send_byte(8'h47); wait_tx(base, 1);
    check("g2_hold", hold, 1'b0);

    // Reset in the middle of a reply.
    base = tx_q.size(); w0 = wr_cnt; re0 = re_cyc;
`ifdef RV_DBGBR_READ_EN
    send_byte(8'h52); send_word(32'h00000100);
    wait_tx(base, 2);
    xreset = 1'b0;
    repeat (2) @(negedge clk);
    xreset = 1'b1;
    repeat (10) @(negedge clk);
    check("rr_tx_count", tx_q.size() - base, 2);
    check("rr_no_bus",   re_cyc - re0,       1);
`else
    bus.tx_ready = 1'b0;
    send_byte(8'h57); send_word(32'h00000400); send_word(32'hCAFEF00D);
    repeat (3) @(negedge clk);
    check("rr_pending", bus.tx_valid, 1'b1);
    xreset = 1'b0;
    repeat (2) @(negedge clk);
    xreset = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rr_tx_count", tx_q.size() - base, 0);
    check("rr_no_bus",   wr_cnt - w0,        1);
`endif
    check("rr_idle", busy, 1'b0);
    check("rr_hold", hold, 1'b1);
    base = tx_q.size();
    send_byte(8'h5A); wait_tx(base, 1);
    check("rr_unk_tx", txb(base), 8'h3F);

    check("never_we_and_re", both_cyc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_dbgbr.md
RV_DBGBR -- requirements
Module: rv_dbgbr

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 480000, the inter-byte timeout in clk cycles (10 ms at 48 MHz).
REQ-002 SHALL have port clk  in  1  system clock (cclk domain); the block uses one clock.
REQ-003 SHALL have port xreset  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports rx_data  in  8  and rx_valid  in  1: received command byte and its single-cycle strobe.
REQ-005 SHALL have ports tx_data  out  8, tx_valid  out  1, tx_ready  in  1: reply byte stream.
REQ-006 SHALL have ports m_adr  out  32, m_we  out  4, m_dw  out  32, m_re  out  1: bus initiator request.
REQ-007 SHALL have ports m_dr  in  32 and m_rdy  in  1: read data (one-cycle latency) and bus ready.
REQ-008 SHALL have ports hold  out  1 (keeps the CPU in reset and gives the bus to this block) and busy  out  1 (not IDLE).

Function
REQ-009 SHALL parse little-endian commands: 'W'(0x57)+addr4+data4; 'R'(0x52)+addr4; 'H'(0x48); 'G'(0x47).
REQ-010 SHALL use FSM states IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_WAIT, REPLY.
REQ-011 SHALL, in IDLE, take W or R to ADDR with byte count 0; H sets hold=1 and G clears it, each replying 'K'(0x4B); any other byte replies '?'(0x3F).
REQ-012 SHALL, in ADDR, shift in 4 bytes; after the 4th it SHALL go to DATA for W, or BUS_RD for R.
REQ-013 SHALL, in DATA, shift in 4 bytes and then go to BUS_WR.
REQ-014 SHALL, in BUS_WR, drive m_we=4'hF, m_adr, m_dw until a cycle with m_rdy=1, then reply 'K'.
REQ-015 SHALL, in BUS_RD, assert m_re until m_rdy=1; RD_WAIT SHALL capture m_dr on the next cycle; REPLY SHALL then send 4 bytes, LSB first.
REQ-016 SHALL drive m_adr[1:0] to 2'b00 on every access (word aligned).
REQ-017 SHALL keep m_we=0 and m_re=0 outside BUS_WR and BUS_RD, and never assert both.
REQ-018 SHALL hold tx_valid until tx_ready; a byte transfers in a cycle where both are 1; the FSM SHALL return to IDLE after the last reply byte.
REQ-019 SHALL ignore rx_valid during BUS_WR, BUS_RD, RD_WAIT and REPLY, dropping those bytes without side effects.
REQ-020 SHALL, if rx_valid does not arrive within TMO_CYCLES while in ADDR or DATA, return to IDLE silently; the timeout counter SHALL restart on every accepted byte.
REQ-021 SHALL not apply a timeout to bus waits, so m_rdy stalls are unbounded.
REQ-022 SHALL, when a byte arrives in the same cycle the timeout expires, accept the byte and not time out.
REQ-023 SHALL change hold only through H, G and reset; hold SHALL be independent of FSM state.

Reset
REQ-024 SHALL, on xreset=0, asynchronously set state=IDLE, hold=1, tx_valid=0, tx_data=0, m_we=0, m_re=0, m_adr=0, m_dw=0, busy=0, and clear all counters.
REQ-025 SHALL, on reset asserted mid-transaction, abort the transaction, emit no further reply byte, and start no bus cycle after release.

Configuration
REQ-026 SHALL, with macro RV_DBGBR_READ_EN defined, support the R command as described above.
REQ-027 SHALL, without RV_DBGBR_READ_EN, treat 'R' as unknown and reply '?'; m_re SHALL be tied to 0 and BUS_RD/RD_WAIT SHALL not be synthesized.

Structure
REQ-028 SHALL place the command byte constants, reply constants and the state enum typedef in the shared rv_types package.
REQ-029 SHALL be a single module with no sub-module; byte shift registers and the timeout counter SHALL be inline.

Verification
REQ-030 SHALL cover: W 00000100 DEADBEEF (bytes 57 00 01 00 00 EF BE AD DE) -> one cycle with m_we=F, m_adr=0x100, m_dw=0xDEADBEEF, then tx 0x4B.
REQ-031 SHALL cover: R 0x100 with the model returning 0xDEADBEEF -> m_re for 1 cycle, then tx EF BE AD DE in order.
REQ-032 SHALL cover: H then G -> tx 4B, 4B; hold goes 1 then 0; after reset hold=1.
REQ-033 SHALL cover: 57 00 01 then idle for TMO_CYCLES+1 -> IDLE, no bus cycle, no tx; a following 0x48 replies 4B.
REQ-034 SHALL cover: m_rdy held 0 for 20 cycles during W -> m_we stays F and stable, and the write completes when m_rdy rises.
REQ-035 SHALL cover: xreset pulsed during REPLY after 2 bytes -> no more tx bytes, state IDLE; byte 0x5A -> tx 3F.
